// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: strobes columns, debounces full scans,
// reports each new key as a hex code with a one-cycle valid pulse.
//
// Ports:
//   Clk      - system clock
//   Rst      - synchronous reset, active-high
//   Row      - keypad rows, active-low, asynchronous
//   Col      - column drive, active-low, one bit low at a time
//   KeyCode  - hex code of the last accepted key
//   KeyValid - one-cycle pulse when a new key is accepted
//   KeyHeld  - high while the accepted key is considered pressed
//   Number   - last four accepted keys, newest in [3:0]
module hex_keypad_scanner #(
    parameter int SCAN_DIV       = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    output logic        KeyHeld,
    output logic [15:0] Number
);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic [3:0]          row_meta;
    logic [3:0]          row_sync;
    logic [SCAN_DIV-1:0] dwell;
    logic [1:0]          col_idx;
    logic [1:0]          acc_cnt;
    logic [3:0]          acc_code;
    state_t              state;
    logic [3:0]          cand;
    logic [3:0]          match;
    logic [3:0]          rel;

    logic       dwell_end;
    logic       scan_done;
    logic [3:0] row_hit;
    logic [2:0] col_cnt;
    logic [1:0] col_row;
    logic [2:0] tot;
    logic [1:0] new_cnt;
    logic [3:0] new_code;
    logic       is_none;
    logic       is_single;

    function automatic logic [3:0] key_map(input logic [1:0] r,
                                           input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        unique case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            4'hF: k = 4'hD;
        endcase
        return k;
    endfunction

    assign dwell_end = &dwell;
    assign scan_done = dwell_end && (col_idx == 2'd3);
    assign row_hit   = ~row_sync;

    always_comb begin
        col_cnt = {2'b00, row_hit[0]} + {2'b00, row_hit[1]}
                + {2'b00, row_hit[2]} + {2'b00, row_hit[3]};
        col_row = 2'd0;
        if (row_hit[1]) col_row = 2'd1;
        if (row_hit[2]) col_row = 2'd2;
        if (row_hit[3]) col_row = 2'd3;
        // Hit total saturates at 2: anything beyond one hit is MULTI.
        tot     = {1'b0, acc_cnt} + col_cnt;
        new_cnt = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        new_code = acc_code;
        if (acc_cnt == 2'd0 && col_cnt == 3'd1)
            new_code = key_map(col_row, col_idx);
        is_none   = (new_cnt == 2'd0);
        is_single = (new_cnt == 2'd1);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            dwell    <= '0;
            col_idx  <= 2'd0;
            Col      <= 4'b1110;
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
            state    <= IDLE;
            cand     <= 4'h0;
            match    <= 4'h0;
            rel      <= 4'h0;
            KeyCode  <= 4'h0;
            KeyValid <= 1'b0;
            KeyHeld  <= 1'b0;
            Number   <= 16'h0000;
        end else begin
            row_meta <= Row;
            row_sync <= row_meta;
            dwell    <= dwell + SCAN_DIV'(1);
            // Column drive lags the index by one cycle.
            Col      <= ~(4'b0001 << col_idx);
            KeyValid <= 1'b0;
            if (dwell_end) begin
                col_idx <= col_idx + 2'd1;
                if (scan_done) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_cnt  <= new_cnt;
                    acc_code <= new_code;
                end
            end
            if (scan_done) begin
                unique case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand  <= new_code;
                            match <= 4'd1;
                            state <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (is_single && new_code == cand) begin
                            if (match + 4'd1 == DB) begin
                                KeyCode  <= cand;
                                Number   <= {Number[11:0], cand};
                                KeyValid <= 1'b1;
                                KeyHeld  <= 1'b1;
                                state    <= PRESSED;
                            end else begin
                                match <= match + 4'd1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (is_none) begin
                            rel   <= 4'd1;
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (is_none) begin
                            if (rel + 4'd1 == DB) begin
                                KeyHeld <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                rel <= rel + 4'd1;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner with a keypad model
// and a scan-level debounce reference.
module tb_hex_keypad_scanner;

    localparam int SD   = 2;
    localparam int DB   = 4;
    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] number;
    logic [15:0] pressed = 16'h0000;

    always #5 clk = ~clk;

    hex_keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .Row(row),
        .Col(col),
        .KeyCode(key_code),
        .KeyValid(key_valid),
        .KeyHeld(key_held),
        .Number(number)
    );

    // Physical position of each hex code on the pad.
    int key_row[16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int key_col[16] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 1};

    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++)
            if (pressed[k] && !col[key_col[k]])
                row[key_row[k]] = 1'b0;
    end

    int checks = 0;
    int failures = 0;

    int valid_bad = 0;
    int state_bad = 0;
    int col_bad   = 0;
    int pulses    = 0;
    int m_pulses  = 0;

    logic        m_held;
    logic        m_pulse;
    int          m_streak;
    int          m_quiet;
    logic [3:0]  m_key;
    logic [3:0]  m_code;
    logic [15:0] m_num;
    logic        first_scan;

    int b_valid, b_state, b_col, b_pulses;

    task automatic model_reset();
        m_held = 1'b0;
        m_pulse = 1'b0;
        m_streak = 0;
        m_quiet = 0;
        m_key = 4'h0;
        m_code = 4'h0;
        m_num = 16'h0000;
        first_scan = 1'b1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic mark();
        b_valid = valid_bad;
        b_state = state_bad;
        b_col = col_bad;
        b_pulses = pulses;
    endtask

    // One full scan with a fixed key set; starts and ends at the
    // negedge of the column-0 first dwell cycle.
    task automatic do_scan(input logic [15:0] mask);
        int n;
        int ci;
        logic [3:0] ec;
        logic [3:0] code;
        pressed = mask;
        for (int i = 0; i < SCAN; i++) begin
            if (i == 0) ci = first_scan ? 0 : 3;
            else ci = (i - 1) / 4;
            ec = ~(4'b0001 << ci);
            if (col !== ec) col_bad++;
            if (i == 0) begin
                if (key_valid !== m_pulse) valid_bad++;
                if (key_held !== m_held || key_code !== m_code ||
                    number !== m_num) state_bad++;
            end else if (key_valid !== 1'b0) begin
                valid_bad++;
            end
            if (key_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        first_scan = 1'b0;
        n = $countones(mask);
        code = 4'h0;
        for (int k = 0; k < 16; k++)
            if (mask[k]) code = 4'(k);
        m_pulse = 1'b0;
        if (!m_held) begin
            if (n == 1 && m_streak > 0 && code == m_key) begin
                m_streak++;
            end else if (n == 1 && m_streak == 0) begin
                m_streak = 1;
                m_key = code;
            end else begin
                m_streak = 0;
            end
            if (m_streak == DB) begin
                m_pulse = 1'b1;
                m_held = 1'b1;
                m_code = m_key;
                m_num = {m_num[11:0], m_key};
                m_streak = 0;
                m_pulses++;
            end
        end else begin
            if (n == 0) m_quiet++;
            else m_quiet = 0;
            if (m_quiet == DB) begin
                m_held = 1'b0;
                m_quiet = 0;
            end
        end
    endtask

    task automatic check_tallies(input string tag);
        checks++;
        if (valid_bad - b_valid !== 0) begin
            failures++;
            $display("FAIL %s valid_timing got %0d bad scans want 0",
                     tag, valid_bad - b_valid);
        end
        checks++;
        if (state_bad - b_state !== 0) begin
            failures++;
            $display("FAIL %s outputs got %0d bad scans want 0",
                     tag, state_bad - b_state);
        end
        checks++;
        if (col_bad - b_col !== 0) begin
            failures++;
            $display("FAIL %s col_seq got %0d bad cycles want 0",
                     tag, col_bad - b_col);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        checks++;
        if (col !== 4'b1110) begin
            failures++;
            $display("FAIL rst_col got %b want 1110", col);
        end
        checks++;
        if (key_code !== 4'h0) begin
            failures++;
            $display("FAIL rst_code got %h want 0", key_code);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got %b want 0", key_valid);
        end
        checks++;
        if (key_held !== 1'b0) begin
            failures++;
            $display("FAIL rst_held got %b want 0", key_held);
        end
        checks++;
        if (number !== 16'h0000) begin
            failures++;
            $display("FAIL rst_number got %h want 0000", number);
        end
        mark();
        do_scan(16'h0000);
        do_scan(16'h0000);
        check_tallies("reset");
    endtask

    task automatic test_clean_press();
        mark();
        repeat (8) do_scan(16'h0001 << 5);
        checks++;
        if (key_held !== 1'b1) begin
            failures++;
            $display("FAIL clean_held got %b want 1", key_held);
        end
        repeat (6) do_scan(16'h0000);
        checks++;
        if (pulses - b_pulses !== 1) begin
            failures++;
            $display("FAIL clean_pulses got %0d want 1", pulses - b_pulses);
        end
        checks++;
        if (key_code !== 4'h5 || number !== 16'h0005) begin
            failures++;
            $display("FAIL clean_code got %h/%h want 5/0005",
                     key_code, number);
        end
        checks++;
        if (key_held !== 1'b0) begin
            failures++;
            $display("FAIL clean_release got %b want 0", key_held);
        end
        check_tallies("clean");
    endtask

    task automatic test_bounce();
        mark();
        do_scan(16'h0001 << 9);
        do_scan(16'h0000);
        do_scan(16'h0001 << 9);
        do_scan(16'h0000);
        checks++;
        if (pulses - b_pulses !== 0) begin
            failures++;
            $display("FAIL bounce_early got %0d pulses want 0",
                     pulses - b_pulses);
        end
        repeat (5) do_scan(16'h0001 << 9);
        repeat (6) do_scan(16'h0000);
        checks++;
        if (pulses - b_pulses !== 1 || key_code !== 4'h9) begin
            failures++;
            $display("FAIL bounce_accept got %0d/%h want 1/9",
                     pulses - b_pulses, key_code);
        end
        check_tallies("bounce");
    endtask

    task automatic test_ghost_glitch();
        mark();
        repeat (8) do_scan((16'h0001 << 1) | (16'h0001 << 2));
        repeat (2) do_scan(16'h0000);
        checks++;
        if (pulses - b_pulses !== 0 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL ghost got %0d pulses held=%b want 0/0",
                     pulses - b_pulses, key_held);
        end
        repeat (5) do_scan(16'h0001 << 12);
        do_scan(16'h0000);
        repeat (3) do_scan(16'h0001 << 12);
        checks++;
        if (key_held !== 1'b1) begin
            failures++;
            $display("FAIL glitch_held got %b want 1", key_held);
        end
        repeat (6) do_scan(16'h0000);
        checks++;
        if (pulses - b_pulses !== 1 || key_code !== 4'hC) begin
            failures++;
            $display("FAIL glitch got %0d/%h want 1/C",
                     pulses - b_pulses, key_code);
        end
        check_tallies("ghost");
    endtask

    task automatic test_sequence();
        logic [3:0] seq[4] = '{4'h1, 4'h2, 4'h3, 4'hA};
        do_reset(2);
        mark();
        for (int s = 0; s < 4; s++) begin
            repeat (5) do_scan(16'h0001 << seq[s]);
            repeat (5) do_scan(16'h0000);
        end
        checks++;
        if (pulses - b_pulses !== 4) begin
            failures++;
            $display("FAIL seq_pulses got %0d want 4", pulses - b_pulses);
        end
        checks++;
        if (number !== 16'h123A || key_code !== 4'hA) begin
            failures++;
            $display("FAIL seq_number got %h/%h want 123A/A",
                     number, key_code);
        end
        check_tallies("sequence");
    endtask

    task automatic test_reset_mid();
        mark();
        repeat (6) do_scan(16'h0001 << 14);
        checks++;
        if (key_held !== 1'b1) begin
            failures++;
            $display("FAIL mid_held got %b want 1", key_held);
        end
        do_reset(1);
        checks++;
        if (key_held !== 1'b0 || key_code !== 4'h0 ||
            number !== 16'h0000 || col !== 4'b1110) begin
            failures++;
            $display("FAIL mid_clear got %b/%h/%h/%b want 0/0/0000/1110",
                     key_held, key_code, number, col);
        end
        repeat (5) do_scan(16'h0001 << 14);
        repeat (6) do_scan(16'h0000);
        checks++;
        if (pulses - b_pulses !== 2) begin
            failures++;
            $display("FAIL mid_pulses got %0d want 2", pulses - b_pulses);
        end
        checks++;
        if (key_code !== 4'hE || number !== 16'h000E) begin
            failures++;
            $display("FAIL mid_code got %h/%h want E/000E",
                     key_code, number);
        end
        check_tallies("reset_mid");
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int r;
        int mp0;
        mask = 16'h0000;
        mark();
        mp0 = m_pulses;
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 3) begin
                    mask = 16'h0000;
                end else if (r < 9) begin
                    mask = 16'h0001 << $urandom_range(0, 15);
                end else begin
                    mask = 16'h0001 << $urandom_range(0, 7);
                    mask = mask | (16'h0100 << $urandom_range(0, 7));
                end
            end
            do_scan(mask);
        end
        repeat (6) do_scan(16'h0000);
        checks++;
        if (pulses - b_pulses !== m_pulses - mp0) begin
            failures++;
            $display("FAIL rand_pulses got %0d want %0d",
                     pulses - b_pulses, m_pulses - mp0);
        end
        checks++;
        if (number !== m_num || key_code !== m_code) begin
            failures++;
            $display("FAIL rand_final got %h/%h want %h/%h",
                     number, key_code, m_num, m_code);
        end
        check_tallies("random");
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost_glitch();
        test_sequence();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
